mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle MIPS datapath's unified instruction/data memory port.
- Accepts one word request at a time (fetch, load or store) over a req/ready handshake.
- Inserts a configurable number of wait states, then commits the write or returns read data with a one-cycle ready pulse.
- Replaces the zero-latency combined memory so the datapath's control FSM can be exercised against a realistic slow memory.

Parameters:
- DEPTH_BITS, 10, log2 of memory depth in 32-bit words (default 1024 words).
- WAIT_STATES, 2, wait cycles between request acceptance and completion; legal range 0..15.
- INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty.

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- req  input  1  request valid from the datapath; sampled only in IDLE.
- addr  input  32  byte address (instruction or data).
- writeData  input  32  store data.
- writeEnable  input  1  1 = store, 0 = read/fetch; sampled with req.
- readData  output  32  registered read result; valid while ready=1 and held until the next completion.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `resetN` is asynchronous and active-low.
- Reset values: state=IDLE, ready=0, busy=0, readData=0, wait counter=0, latched request registers=0. Memory array contents are not reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with req=1, latch addr, writeData and writeEnable.
  - If WAIT_STATES=0, go to DONE. Otherwise load counter = WAIT_STATES-1 and go to WAIT.
  - req=0 keeps the block in IDLE.
- WAIT: at each edge, if counter=0 go to DONE, else decrement. The req, addr, writeData and writeEnable inputs are ignored.
- Access commit, on the edge entering DONE:
  - Word index = latched addr[DEPTH_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth.
  - If writeEnable is latched high, mem[index] is written and readData is loaded with the new data (write-through).
  - Otherwise readData is loaded with mem[index].
- DONE: ready=1 for exactly this cycle. Next edge returns to IDLE unconditionally; req is not sampled in DONE.
- Latency: accepted at edge E0, ready is high from edge E0+WAIT_STATES to edge E0+WAIT_STATES+1. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Initiator rule: the datapath drops req in the cycle ready=1. If req is still high in the following IDLE cycle, it is accepted as a new request.
- addr[1:0] is ignored for indexing.
- Reset mid-operation: an asynchronous resetN assertion in WAIT aborts the access. No write occurs, ready never pulses, and the FSM is in IDLE after release. A write already committed on entry to DONE stays committed.
- ready and busy are registered state decodes and never combinational functions of req.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port `misaligned` (1 bit), reset value 0.
  - At acceptance, if addr[1:0] != 0, the request still runs its full latency, but no write is performed and readData is loaded with 32'hDEADBEEF.
  - misaligned=1 during the DONE cycle only, and 0 otherwise.
- Not defined: the port does not exist, and addr[1:0] is silently ignored.

Test Plan:
- Reset then store: resetN low then high, WAIT_STATES=2. req=1, writeEnable=1, addr=32'h40, writeData=32'hCAFEF00D accepted at E0 -> busy=1 from E0; ready=1 only between E2 and E3; readData=32'hCAFEF00D; busy=0 after E3.
- Read-back: read of addr=32'h40 -> ready exactly 2 edges after acceptance; readData=32'hCAFEF00D. Read of 32'h44 after INIT_FILE preload of word 17 = 32'h20020005 -> readData=32'h20020005.
- Wrap-around: DEPTH_BITS=10. Store 32'h12345678 to addr=32'h1000, then read addr=32'h0 -> readData=32'h12345678.
- Held request and zero wait: WAIT_STATES=0, req held high for 4 cycles -> ready pulses in alternating cycles, two completions; ready never high for 2 consecutive cycles.
- Reset abort: store of 32'hFFFFFFFF to 32'h80 with resetN pulsed low during WAIT -> no ready pulse; a later read of 32'h80 returns its prior value; readData=0 immediately after reset.
- Alignment check: with MEM_ALIGN_CHECK_EN defined, store to addr=32'h42 -> misaligned=1 and readData=32'hDEADBEEF in the DONE cycle; a later read of 32'h40 returns unchanged data.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Slow memory model for the multicycle MIPS unified memory port.
//            Accepts one word request at a time over req/ready, inserts
//            WAIT_STATES wait cycles, then commits a store or returns read
//            data with a one-cycle ready pulse.
// Options  : MEM_ALIGN_CHECK_EN adds the 'misaligned' output and poisons
//            requests whose byte address is not word aligned.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int    DEPTH_BITS  = 10,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic        writeEnable,
    output logic [31:0] readData,
    output logic        ready,
    output logic        busy
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misaligned
`endif
);

    localparam int          DEPTH     = 1 << DEPTH_BITS;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [31:0] POISON    = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [DEPTH_BITS-1:0] lat_idx;
    logic [31:0]           lat_wdata;
    logic                  lat_we;
    logic                  lat_mis;

    logic [31:0]           mem [DEPTH];

    logic                  req_mis;
    logic                  commit_now;
    logic [DEPTH_BITS-1:0] commit_idx;
    logic [31:0]           commit_wdata;
    logic                  commit_we;
    logic                  commit_mis;
    logic                  commit_write;
    logic [31:0]           commit_rdata;

    // Address bits outside the word index never influence the access
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:DEPTH_BITS+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign req_mis = (addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    // Select the request being committed: the live inputs when a zero-wait
    // request goes straight from IDLE to DONE, otherwise the latched copy
    always_comb begin
        commit_now   = 1'b0;
        commit_idx   = lat_idx;
        commit_wdata = lat_wdata;
        commit_we    = lat_we;
        commit_mis   = lat_mis;
        if (state == S_IDLE) begin
            commit_idx   = addr[DEPTH_BITS+1:2];
            commit_wdata = writeData;
            commit_we    = writeEnable;
            commit_mis   = req_mis;
            commit_now   = req && (WAIT_STATES == 0);
        end else if (state == S_WAIT) begin
            commit_now   = (wait_cnt == 4'd0);
        end
        commit_write = commit_now && commit_we && !commit_mis;
        if (commit_mis) begin
            commit_rdata = POISON;
        end else if (commit_we) begin
            commit_rdata = commit_wdata;
        end else begin
            commit_rdata = mem[commit_idx];
        end
    end

    // Memory array write port; contents are not reset, and no store may land
    // while reset is held
    always_ff @(posedge clock) begin
        if (resetN && commit_write) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    // Request FSM with registered ready/busy/readData
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            readData  <= 32'd0;
            ready     <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_idx   <= addr[DEPTH_BITS+1:2];
                        lat_wdata <= writeData;
                        lat_we    <= writeEnable;
                        lat_mis   <= req_mis;
                        busy      <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state    <= S_DONE;
                            ready    <= 1'b1;
                            readData <= commit_rdata;
`ifdef MEM_ALIGN_CHECK_EN
                            misaligned <= commit_mis;
`endif
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= S_DONE;
                        ready    <= 1'b1;
                        readData <= commit_rdata;
`ifdef MEM_ALIGN_CHECK_EN
                        misaligned <= commit_mis;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
